// File: rtl/tristate_bus_ctrl.sv
// Round-robin owner arbitration for a shared tristate bus, with an all-off turnaround gap between owners.
// Optional hold timeout is compiled in with `define TRISTATE_BUS_CTRL_TIMEOUT_EN.
module tristate_bus_ctrl #(
  parameter  int unsigned N_DRV    = 4,
  parameter  int unsigned TURN_CYC = 1,
  parameter  int unsigned HOLD_MAX = 8,
  localparam int unsigned OW       = $clog2(N_DRV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DRV-1:0] req,
  output logic [N_DRV-1:0] en,
  output logic [OW-1:0]    owner,
  output logic             busy,
  output logic             bus_float
);

  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  if (N_DRV < 2 || N_DRV > 16) begin : g_bad_n_drv
    $error("N_DRV must be in 2..16");
  end
  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn_cyc
    $error("TURN_CYC must be in 1..15");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("HOLD_MAX must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_DRV-1:0] en_q, en_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             float_q, float_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic             win_vld;
  logic [OW-1:0]    win_idx;
  logic [OW-1:0]    win_nxt;
  logic             hold_done;

  // First requester at or above ptr, wrapping past the top driver.
  always_comb begin
    int unsigned k;
    logic [OW-1:0] kk;
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    kk      = '0;
    for (int unsigned i = 0; i < N_DRV; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= N_DRV) begin
        k = k - N_DRV;
      end
      kk = OW'(k);
      if (!win_vld && req[kk]) begin
        win_vld = 1'b1;
        win_idx = kk;
      end
    end
  end

  assign win_nxt = (win_idx == OW'(N_DRV - 1)) ? '0 : win_idx + OW'(1);

`ifdef TRISTATE_BUS_CTRL_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hcnt_q, hcnt_d;

  assign hold_done = (hcnt_q == HW'(HOLD_MAX - 1));

  // Consecutive drive cycles of the current owner, saturating.
  always_comb begin
    hcnt_d = hcnt_q;
    if (state_d == DRIVE && state_q != DRIVE) begin
      hcnt_d = '0;
    end else if (state_q == DRIVE && hcnt_q != HW'(HOLD_MAX)) begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  assign hold_done = 1'b0;
`endif

  // Next-state and registered output values.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    float_d = float_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = DRIVE;
          en_d    = N_DRV'(1) << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
          float_d = 1'b0;
          ptr_d   = win_nxt;
        end
      end

      DRIVE: begin
        if (!req[owner_q] || hold_done) begin
          state_d = TURN;
          en_d    = '0;
          busy_d  = 1'b0;
          float_d = 1'b1;
          tcnt_d  = '0;
        end
      end

      TURN: begin
        if (tcnt_q == TW'(TURN_CYC - 1)) begin
          if (win_vld) begin
            state_d = DRIVE;
            en_d    = N_DRV'(1) << win_idx;
            owner_d = win_idx;
            busy_d  = 1'b1;
            float_d = 1'b0;
            ptr_d   = win_nxt;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = '0;
        busy_d  = 1'b0;
        float_d = 1'b1;
      end
    endcase
  end

  // Reset drops every enable immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      float_q <= 1'b1;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      float_q <= float_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign en        = en_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign bus_float = float_q;

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Bench for tristate_bus_ctrl: two instances (TURN_CYC=1 and 3) checked every cycle against an ownership model.
module tb_tristate_bus_ctrl;

  localparam int HOLD = 8;
`ifdef TRISTATE_BUS_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
  logic [3:0] en_a, en_b;
  logic [1:0] own_a, own_b;
  logic       busy_a, busy_b, flt_a, flt_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tristate_bus_ctrl #(.N_DRV(4), .TURN_CYC(1), .HOLD_MAX(HOLD)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .en(en_a), .owner(own_a),
    .busy(busy_a), .bus_float(flt_a));

  tristate_bus_ctrl #(.N_DRV(4), .TURN_CYC(3), .HOLD_MAX(HOLD)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .en(en_b), .owner(own_b),
    .busy(busy_b), .bus_float(flt_b));

  // own = -1 when nobody drives; gap = all-off cycles still owed; held = cycles driven so far.
  typedef struct {
    int own;
    int gap;
    int held;
    int ptr;
  } mdl_t;

  localparam mdl_t MDL_RST = '{own: -1, gap: 0, held: 0, ptr: 0};

  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  function automatic mdl_t mdl_step(mdl_t m, logic [3:0] r, int tc);
    mdl_t n = m;
    if (m.own >= 0) begin
      if (!r[m.own] || (TMO && m.held == HOLD)) begin
        n.own  = -1;
        n.gap  = tc;
        n.held = 0;
      end else if (m.held < HOLD) begin
        n.held = m.held + 1;
      end
    end else if (m.gap > 1) begin
      n.gap = m.gap - 1;
    end else begin
      n.gap = 0;
      for (int i = 0; i < 4; i++) begin
        int w;
        w = (m.ptr + i) % 4;
        if (n.own < 0 && r[w]) begin
          n.own  = w;
          n.held = 1;
          n.ptr  = (w + 1) % 4;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= MDL_RST;
      mb <= MDL_RST;
    end else begin
      ma <= mdl_step(ma, req_a, 1);
      mb <= mdl_step(mb, req_b, 3);
    end
  end

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_dut(string nm, logic [3:0] e, logic [1:0] o, logic b, logic f, mdl_t m);
    logic [3:0] xe;
    xe = (m.own >= 0) ? 4'(1 << m.own) : 4'h0;
    check({nm, "_en"}, 32'(e), 32'(xe));
    check({nm, "_busy_float"}, 32'({b, f}), 32'({m.own >= 0, m.own < 0}));
    check({nm, "_onehot0"}, 32'($onehot0(e)), 32'd1);
    if (m.own >= 0) begin
      check({nm, "_owner"}, 32'(o), 32'(m.own));
    end
  endtask

  always @(negedge clk) begin
    cmp_dut("a", en_a, own_a, busy_a, flt_a, ma);
    cmp_dut("b", en_b, own_b, busy_b, flt_b, mb);
  end

  function automatic int idx_of(logic [3:0] e);
    int r = -1;
    for (int i = 0; i < 4; i++) if (e[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 4'h0;
    req_b = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] vec_tab [18] = '{4'h0, 4'hA, 4'hA, 4'h8, 4'h8, 4'h0, 4'h6, 4'h6, 4'h7,
                               4'h5, 4'h1, 4'h1, 4'h9, 4'h0, 4'hF, 4'hE, 4'hC, 4'h0};

  initial begin
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    int grants[$];
    int gaps[$];
    int run, zeros, seen0;
    logic [3:0] prev;

    // Reset held with every driver requesting.
    req_a = 4'hF;
    req_b = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(en_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_float", 32'(flt_a), 32'h1);
    check("rst_owner", 32'(own_a), 32'h0);
    req_a = 4'h0;
    req_b = 4'h0;
    rst_n = 1'b1;

    // Single request from driver 2, dropped before edge 5.
    do_reset();
    req_a = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_en", 32'(en_a), 32'h4);
      check("single_owner", 32'(own_a), 32'd2);
    end
    req_a = 4'h0;
    @(negedge clk);
    check("single_release_en", 32'(en_a), 32'h0);
    check("single_release_float", 32'(flt_a), 32'h1);
    @(negedge clk);
    check("single_idle_en", 32'(en_a), 32'h0);

    // Round robin with every owner briefly dropping its request after two drive cycles.
    do_reset();
    prev = 4'h0;
    run = 0;
    zeros = 0;
    for (int c = 0; c < 80 && grants.size() < 5; c++) begin
      @(negedge clk);
      req_a = 4'hF;
      if (en_a != 4'h0) begin
        if (prev == 4'h0) begin
          grants.push_back(idx_of(en_a));
          gaps.push_back(zeros);
          run = 0;
        end
        run++;
        zeros = 0;
        if (run == 2) req_a = 4'hF & ~en_a;
      end else begin
        zeros++;
      end
      prev = en_a;
    end
    req_a = 4'h0;
    check("rr_grant_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      check("rr_order", 32'(grants[i]), 32'(exp_rr[i]));
      if (i > 0) check("rr_gap", 32'(gaps[i]), 32'd1);
    end

    // Three-cycle turnaround between drivers 0 and 1.
    do_reset();
    req_b = 4'b0011;
    seen0 = 0;
    zeros = 0;
    prev = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (en_b == 4'b0010) break;
      if (en_b == 4'b0001) begin
        seen0++;
        if (seen0 == 2) req_b = 4'b0010;
      end else if (seen0 > 0) begin
        zeros++;
      end
      prev = en_b;
    end
    check("turn3_first", 32'(seen0), 32'd2);
    check("turn3_next_en", 32'(en_b), 32'h2);
    check("turn3_gap", 32'(zeros), 32'd3);
    req_b = 4'h0;

    // Directed request sequence on both instances, checked by the model.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req_a = vec_tab[i];
      req_b = vec_tab[17 - i];
      @(negedge clk);
    end
    req_a = 4'h0;
    req_b = 4'h0;
    repeat (4) @(negedge clk);

`ifdef TRISTATE_BUS_CTRL_TIMEOUT_EN
    // Sole requester is forced off after HOLD cycles and re-granted after one idle cycle.
    do_reset();
    req_a = 4'b0001;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      check("tmo_solo_en", 32'(en_a), ((c % 9) < 8) ? 32'h1 : 32'h0);
    end
    do_reset();
    req_a = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("tmo_pair_en", 32'(en_a), (c < 8) ? 32'h1 : ((c == 8) ? 32'h0 : 32'h2));
    end
    req_a = 4'h0;
`else
    // Without the timeout a held request keeps the bus indefinitely.
    do_reset();
    req_a = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("hold_en", 32'(en_a), 32'h1);
      check("hold_float", 32'(flt_a), 32'h0);
    end
    req_a = 4'h0;
`endif

    // Asynchronous reset in the middle of a drive cycle.
    do_reset();
    req_a = 4'b0010;
    repeat (3) @(negedge clk);
    check("async_pre_en", 32'(en_a), 32'h2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_en", 32'(en_a), 32'h0);
    check("async_busy", 32'(busy_a), 32'h0);
    check("async_float", 32'(flt_a), 32'h1);
    req_a = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
